wr_req_arbiter: RTL and testbench

- Sole owner of the CCI write-request channel.
- Shares the channel between two requesters:
  - the DSM status updater, which writes one 512-bit line to a physical DSM address;
  - the result writeback stream, which writes a sequence of 512-bit lines to a virtual output buffer.
- Sequences line addressing for results, throttles on almostfull, prevents starvation of results by status updates, and emits the registered CCI request.

---
 rtl/cci_pkg.sv | 24 ++
 rtl/wr_req_arbiter_if.sv | 32 +++
 rtl/wr_line_addr_gen.sv | 61 ++++++
 rtl/wr_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wr_req_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cci_pkg.sv
// Shared CCI write-request definitions.
//   wr_req_type_t : request type encodings driven on wr_type (WrLine, WrFence)
//   PV_PHYSICAL / PV_VIRTUAL : values of the wr_pv address-space bit
//   arb_state_t   : write arbiter sequencing states
//   LINE_ADDR_W   : width of a cache-line address (byte address [63:6])
package cci_pkg;

   typedef enum logic [3:0] {
      WR_LINE  = 4'h2,
      WR_FENCE = 4'h5
   } wr_req_type_t;

   localparam logic PV_PHYSICAL = 1'b0;
   localparam logic PV_VIRTUAL  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

   localparam int LINE_ADDR_W = 58;

endpackage

// File: rtl/wr_req_arbiter_if.sv
// CCI write-request channel as seen by its single owner.
// Handshake: the channel has no ready; a request is transferred in every cycle
// wr_valid is 1, and the owner must stop starting new requests while
// almostfull is 1. All wr_* fields are meaningful only while wr_valid is 1.
//   almostfull : channel almost full (slave -> master)
//   wr_valid   : request valid (master -> slave)
//   wr_pv      : 1 = virtual, 0 = physical address
//   wr_type    : request type encoding (WrLine / WrFence)
//   wr_hi_addr : line address bits [57:32]
//   wr_addr    : line address bits [31:0]
//   wr_data    : 512-bit line data
interface wr_req_arbiter_if;

   logic         almostfull;
   logic         wr_valid;
   logic         wr_pv;
   logic [3:0]   wr_type;
   logic [25:0]  wr_hi_addr;
   logic [31:0]  wr_addr;
   logic [511:0] wr_data;

   modport master (
      input  almostfull,
      output wr_valid, wr_pv, wr_type, wr_hi_addr, wr_addr, wr_data
   );

   modport slave (
      output almostfull,
      input  wr_valid, wr_pv, wr_type, wr_hi_addr, wr_addr, wr_data
   );

endinterface

// File: rtl/wr_line_addr_gen.sv
// Result line addressing for the write arbiter.
// Owns the per-pass line offset: it advances on every result grant, wraps to 0
// after the last line of a pass (num_lines-1) and is cleared by start. The
// line address of the current offset is offered combinationally so the
// arbiter can register it with the grant.
//   clk, resetb : clock, synchronous active-low reset
//   start       : clear offset for a new pass
//   advance     : a result line was granted this cycle
//   num_lines   : lines per pass
//   buf_base    : output buffer byte address
//   line_addr   : buf_base[63:6] + offset (58-bit line address)
//   offset      : current line offset
//   res_done    : registered with the grant, so it lines up with wr_valid of
//                 the last line of the pass
module wr_line_addr_gen
   import cci_pkg::*;
#(
   parameter int OFFSET_W = 16
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   start,
   input  logic                   advance,
   input  logic [OFFSET_W-1:0]    num_lines,
   input  logic [63:0]            buf_base,
   output logic [LINE_ADDR_W-1:0] line_addr,
   output logic [OFFSET_W-1:0]    offset,
   output logic                   res_done
);

   logic [OFFSET_W-1:0] offset_q;
   logic                done_q;
   logic                last_line;
   logic                unused_base_bits;

   // The byte offset within a line never contributes to a line address.
   assign unused_base_bits = ^buf_base[5:0];

   assign last_line = (offset_q == (num_lines - OFFSET_W'(1)));
   assign line_addr = buf_base[63:6] + {{(LINE_ADDR_W-OFFSET_W){1'b0}}, offset_q};

   always_ff @(posedge clk) begin
      if (!resetb) begin
         offset_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= advance && last_line;
         if (start) begin
            offset_q <= '0;
         end else if (advance) begin
            // Plain increment also gives the counter-width wrap if num_lines
            // is changed mid-pass to below the current offset.
            offset_q <= last_line ? '0 : offset_q + OFFSET_W'(1);
         end
      end
   end

   assign offset   = offset_q;
   assign res_done = done_q;

endmodule

// File: rtl/wr_req_arbiter.sv
// Sole owner of the CCI write-request channel, shared between the DSM status
// updater (one physical line per request) and the result writeback stream
// (a sequence of virtual lines). Requests are issued at most once per three
// cycles (IDLE -> SEND -> GAP) so that almostfull seen in IDLE is always
// current. A DSM run counter limits consecutive DSM grants while a result is
// waiting, so results cannot be starved.
//   clk, resetb            : clock, synchronous active-low reset
//   write_fence            : issue WrFence instead of WrLine
//   dsm_req/dsm_gnt        : DSM request (held) / one-cycle grant pulse
//   dsm_base, dsm_offset   : DSM line address = dsm_base[37:6] + dsm_offset
//   dsm_data               : DSM status line
//   res_valid/res_ready    : result line available / one-cycle consume pulse
//   res_data               : result line
//   buf_base, num_lines    : output buffer byte address, lines per pass
//   start                  : clears the line offset, blocks grants that cycle
//   res_done               : coincident with wr_valid of a pass's last line
//   tx_count               : total requests issued (wraps at 2^32)
//   state_dbg, offset_dbg  : arbiter state and current result line offset
//   cci                    : CCI write-request channel
module wr_req_arbiter
   import cci_pkg::*;
#(
   parameter int MAX_DSM_RUN = 4,
   parameter int OFFSET_W    = 16
) (
   input  logic                clk,
   input  logic                resetb,
   input  logic                write_fence,
   input  logic                dsm_req,
   input  logic [63:0]         dsm_base,
   input  logic [9:0]          dsm_offset,
   input  logic [511:0]        dsm_data,
   output logic                dsm_gnt,
   input  logic                res_valid,
   input  logic [511:0]        res_data,
   output logic                res_ready,
   input  logic [63:0]         buf_base,
   input  logic [OFFSET_W-1:0] num_lines,
   input  logic                start,
   output logic                res_done,
   output logic [31:0]         tx_count,
   output arb_state_t          state_dbg,
   output logic [OFFSET_W-1:0] offset_dbg,
   wr_req_arbiter_if.master    cci
);

   localparam int               RUN_W   = $clog2(MAX_DSM_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DSM_RUN);

   arb_state_t             state_q, state_d;
   logic                   grant_dsm, grant_res;
   logic                   res_elig;
   logic [RUN_W-1:0]       dsm_run_q;
   logic [LINE_ADDR_W-1:0] res_line;
   logic [31:0]            dsm_line;
   wr_req_type_t           sel_type;
   logic                   unused_dsm_bits;

   logic                   wr_valid_q;
   logic                   wr_pv_q;
   logic [3:0]             wr_type_q;
   logic [25:0]            wr_hi_addr_q;
   logic [31:0]            wr_addr_q;
   logic [511:0]           wr_data_q;
   logic [31:0]            tx_count_q;

   assign unused_dsm_bits = ^{dsm_base[63:38], dsm_base[5:0]};

   assign res_elig = res_valid && (num_lines != '0);
   assign dsm_line = dsm_base[37:6] + {22'd0, dsm_offset};
   assign sel_type = write_fence ? WR_FENCE : WR_LINE;

   wr_line_addr_gen #(
      .OFFSET_W (OFFSET_W)
   ) u_addr_gen (
      .clk       (clk),
      .resetb    (resetb),
      .start     (start),
      .advance   (grant_res),
      .num_lines (num_lines),
      .buf_base  (buf_base),
      .line_addr (res_line),
      .offset    (offset_dbg),
      .res_done  (res_done)
   );

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grants are decided only in IDLE; DSM wins unless a result is eligible and
   // DSM has already had MAX_DSM_RUN consecutive grants.
   always_comb begin
      state_d   = state_q;
      grant_dsm = 1'b0;
      grant_res = 1'b0;
      case (state_q)
         IDLE: begin
            if (resetb && !cci.almostfull && !start) begin
               if (dsm_req && (!res_elig || (dsm_run_q < RUN_MAX))) begin
                  grant_dsm = 1'b1;
               end else if (res_elig) begin
                  grant_res = 1'b1;
               end
            end
            if (grant_dsm || grant_res) begin
               state_d = SEND;
            end
         end
         SEND:    state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign dsm_gnt   = grant_dsm;
   assign res_ready = grant_res;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         dsm_run_q <= '0;
      end else if (grant_res || !res_elig) begin
         dsm_run_q <= '0;
      end else if (grant_dsm && (dsm_run_q < RUN_MAX)) begin
         dsm_run_q <= dsm_run_q + RUN_W'(1);
      end
   end

   // Header and data are captured with the grant and held through SEND.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         wr_valid_q   <= 1'b0;
         wr_pv_q      <= 1'b0;
         wr_type_q    <= 4'd0;
         wr_hi_addr_q <= 26'd0;
         wr_addr_q    <= 32'd0;
         wr_data_q    <= 512'd0;
         tx_count_q   <= 32'd0;
      end else begin
         wr_valid_q <= grant_dsm || grant_res;
         tx_count_q <= tx_count_q + {31'd0, wr_valid_q};
         if (grant_dsm) begin
            wr_pv_q      <= PV_PHYSICAL;
            wr_type_q    <= sel_type;
            wr_hi_addr_q <= 26'd0;
            wr_addr_q    <= dsm_line;
            wr_data_q    <= dsm_data;
         end else if (grant_res) begin
            wr_pv_q      <= PV_VIRTUAL;
            wr_type_q    <= sel_type;
            wr_hi_addr_q <= res_line[57:32];
            wr_addr_q    <= res_line[31:0];
            wr_data_q    <= res_data;
         end
      end
   end

   assign cci.wr_valid   = wr_valid_q;
   assign cci.wr_pv      = wr_pv_q;
   assign cci.wr_type    = wr_type_q;
   assign cci.wr_hi_addr = wr_hi_addr_q;
   assign cci.wr_addr    = wr_addr_q;
   assign cci.wr_data    = wr_data_q;
   assign tx_count       = tx_count_q;
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Bench for wr_req_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (cycle budget, offset, run count)
// and a queue of expected write requests.
module tb_wr_req_arbiter;
   import cci_pkg::*;

   localparam int MAX_RUN = 4;
   localparam int EW      = 576;   // {done, pv, type, hi, addr, data}

   logic         clk;
   logic         resetb;
   logic         write_fence;
   logic         dsm_req;
   logic [63:0]  dsm_base;
   logic [9:0]   dsm_offset;
   logic [511:0] dsm_data;
   logic         dsm_gnt;
   logic         res_valid;
   logic [511:0] res_data;
   logic         res_ready;
   logic [63:0]  buf_base;
   logic [15:0]  num_lines;
   logic         start;
   logic         res_done;
   logic [31:0]  tx_count;
   arb_state_t   state_dbg;
   logic [15:0]  offset_dbg;

   wr_req_arbiter_if cci ();

   wr_req_arbiter #(
      .MAX_DSM_RUN (MAX_RUN),
      .OFFSET_W    (16)
   ) dut (
      .clk         (clk),
      .resetb      (resetb),
      .write_fence (write_fence),
      .dsm_req     (dsm_req),
      .dsm_base    (dsm_base),
      .dsm_offset  (dsm_offset),
      .dsm_data    (dsm_data),
      .dsm_gnt     (dsm_gnt),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_ready   (res_ready),
      .buf_base    (buf_base),
      .num_lines   (num_lines),
      .start       (start),
      .res_done    (res_done),
      .tx_count    (tx_count),
      .state_dbg   (state_dbg),
      .offset_dbg  (offset_dbg),
      .cci         (cci)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard / model state ----------------
   logic [EW-1:0] exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            m_busy = 0;        // cycles before the arbiter may grant again
   int unsigned   m_offset = 0;
   int            m_run = 0;
   logic [31:0]   m_tx = 0;
   bit            m_valid_now = 0;   // a request is expected on the channel now
   bit            last_gd = 0;
   bit            last_gr = 0;

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: predict grants from current inputs, check them, advance the
   // model, clock, then check the channel against the expected queue.
   task automatic cycle();
      bit            elig, can, gd, gr, done;
      logic [63:0]   t64;
      logic [57:0]   line;
      logic [3:0]    et;
      logic [EW-1:0] e, got;
      int unsigned   nl;
      #1;
      nl   = num_lines;
      elig = res_valid && (nl != 0);
      can  = resetb && (m_busy == 0) && !cci.almostfull && !start;
      gd   = can && dsm_req && (!elig || (m_run < MAX_RUN));
      gr   = can && !gd && elig;
      et   = write_fence ? WR_FENCE : WR_LINE;
      done = 0;
      n_cmp++;
      if ({dsm_gnt, res_ready} !== {gd, gr}) begin
         n_err++;
         $display("FAIL grant t=%0t dsm_gnt,res_ready=%b%b expected %b%b", $time, dsm_gnt, res_ready, gd, gr);
      end
      if (gd) begin
         t64 = (dsm_base >> 6) + 64'(dsm_offset);
         exp_q.push_back({1'b0, 1'b0, et, 26'd0, t64[31:0], dsm_data});
      end
      if (gr) begin
         line = 58'(buf_base >> 6) + 58'(m_offset);
         done = (m_offset == nl - 1);
         exp_q.push_back({done, 1'b1, et, line[57:32], line[31:0], res_data});
      end
      if (!resetb) begin
         m_run = 0; m_offset = 0; m_busy = 0; m_tx = 0;
      end else begin
         if (gr || !elig) m_run = 0;
         else if (gd && m_run < MAX_RUN) m_run++;
         if (start) m_offset = 0;
         else if (gr) m_offset = done ? 0 : (m_offset + 1) % 65536;
         m_busy = (gd || gr) ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
         if (m_valid_now) m_tx = m_tx + 1;
      end
      last_gd = gd;
      last_gr = gr;
      @(posedge clk);
      #1;
      m_valid_now = gd || gr;
      n_cmp++;
      if (cci.wr_valid !== m_valid_now) begin
         n_err++;
         $display("FAIL wr_valid t=%0t got %b expected %b", $time, cci.wr_valid, m_valid_now);
      end
      if (m_valid_now && exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {res_done, cci.wr_pv, cci.wr_type, cci.wr_hi_addr, cci.wr_addr, cci.wr_data};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL write_fields t=%0t got done/pv/type/hi/addr=%b/%b/%h/%h/%h expected %b/%b/%h/%h/%h data_ok=%b",
                     $time, got[575], got[574], got[573:570], got[569:544], got[543:512],
                     e[575], e[574], e[573:570], e[569:544], e[543:512], got[511:0] === e[511:0]);
         end
      end else begin
         n_cmp++;
         if (res_done !== 1'b0) begin
            n_err++;
            $display("FAIL res_done_idle t=%0t got %b expected 0", $time, res_done);
         end
      end
      n_cmp++;
      if (tx_count !== m_tx) begin
         n_err++;
         $display("FAIL tx_count t=%0t got %0d expected %0d", $time, tx_count, m_tx);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetb = 1'b0; write_fence = 1'b0; dsm_req = 1'b0; dsm_base = '0;
      dsm_offset = '0; dsm_data = '0; res_valid = 1'b0; res_data = '0;
      buf_base = '0; num_lines = '0; start = 1'b0; cci.almostfull = 1'b0;
      idle_cycles(3);
      n_cmp++;
      if ({cci.wr_valid, cci.wr_pv, cci.wr_type, cci.wr_hi_addr, cci.wr_addr, res_done, dsm_gnt, res_ready} !== '0
          || cci.wr_data !== '0 || tx_count !== 32'd0 || offset_dbg !== 16'd0 || state_dbg !== IDLE) begin
         n_err++;
         $display("FAIL reset_outputs got valid=%b addr=%h tx=%0d off=%0d state=%0d expected all 0 / IDLE",
                  cci.wr_valid, cci.wr_addr, tx_count, offset_dbg, state_dbg);
      end
      resetb = 1'b1;
      cycle();
   endtask

   task automatic test_dsm_only();
      bit got_gnt = 0;
      dsm_base = 64'h1000; dsm_offset = 10'd2; dsm_data = rand512(); dsm_req = 1'b1;
      for (int i = 0; i < 10 && !got_gnt; i++) begin
         cycle();
         got_gnt = last_gd;
      end
      dsm_req = 1'b0;
      n_cmp++;
      if (!got_gnt) begin
         n_err++;
         $display("FAIL dsm_grant_timeout got no dsm_gnt expected one within 10 cycles");
      end
      // 0x1000 >> 6 = 0x40, plus line offset 2
      n_cmp++;
      if (cci.wr_valid !== 1'b1 || cci.wr_addr !== 32'h42 || cci.wr_pv !== 1'b0 || cci.wr_hi_addr !== 26'd0) begin
         n_err++;
         $display("FAIL dsm_header got valid=%b addr=%h pv=%b expected 1/00000042/0", cci.wr_valid, cci.wr_addr, cci.wr_pv);
      end
      cycle();
      n_cmp++;
      if (tx_count !== 32'd1) begin
         n_err++;
         $display("FAIL dsm_tx_count got %0d expected 1", tx_count);
      end
   endtask

   task automatic test_result_pass();
      logic [31:0] addrs[4];
      logic [25:0] his[4];
      logic        dones[4];
      int          cyc[4];
      int          n = 0;
      buf_base = 64'h8000_0000_0000; num_lines = 16'd3;
      start = 1'b1; cycle(); start = 1'b0;
      res_valid = 1'b1;
      for (int c = 0; c < 40 && n < 4; c++) begin
         res_data = rand512();
         cycle();
         if (cci.wr_valid === 1'b1) begin
            addrs[n] = cci.wr_addr; his[n] = cci.wr_hi_addr; dones[n] = res_done; cyc[n] = c; n++;
         end
      end
      res_valid = 1'b0;
      n_cmp++;
      if (n != 4) begin
         n_err++;
         $display("FAIL result_count got %0d writes expected 4", n);
      end else begin
         for (int k = 0; k < 4; k++) begin
            // line address 2^47 >> 6 = 2^41 -> bits [57:32] = 0x200
            n_cmp++;
            if (addrs[k] !== 32'(k % 3) || his[k] !== 26'h200 || dones[k] !== (k == 2)) begin
               n_err++;
               $display("FAIL result_line%0d got addr=%h hi=%h done=%b expected %h/200/%b", k, addrs[k], his[k], dones[k], k % 3, k == 2);
            end
            if (k > 0) begin
               n_cmp++;
               if (cyc[k] - cyc[k-1] != 3) begin
                  n_err++;
                  $display("FAIL result_spacing%0d got %0d cycles expected 3", k, cyc[k] - cyc[k-1]);
               end
            end
         end
      end
      idle_cycles(3);
   endtask

   task automatic test_starvation();
      byte order[$];
      num_lines = 16'd8;
      start = 1'b1; cycle(); start = 1'b0;
      dsm_req = 1'b1; res_valid = 1'b1;
      for (int c = 0; c < 80 && order.size() < 10; c++) begin
         dsm_data = rand512(); res_data = rand512();
         cycle();
         if (last_gd) order.push_back("D");
         if (last_gr) order.push_back("R");
      end
      dsm_req = 1'b0; res_valid = 1'b0;
      n_cmp++;
      if (order.size() != 10) begin
         n_err++;
         $display("FAIL starve_count got %0d grants expected 10", order.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (order[i] != ((i % 5 == 4) ? "R" : "D")) begin
               n_err++;
               $display("FAIL starve_order%0d got %c expected %c", i, order[i], (i % 5 == 4) ? "R" : "D");
            end
         end
      end
      idle_cycles(3);
   endtask

   task automatic test_backpressure();
      int seen = 0;
      cci.almostfull = 1'b1; dsm_req = 1'b1; res_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_gd || last_gr || cci.wr_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL almostfull_block got %0d active cycles expected 0", seen);
      end
      cci.almostfull = 1'b0;
      cycle();
      n_cmp++;
      if (!(last_gd || last_gr)) begin
         n_err++;
         $display("FAIL almostfull_release got no grant expected grant in first free IDLE cycle");
      end
      dsm_req = 1'b0; res_valid = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_start_collision();
      int          g = 0;
      bit          hit = 0;
      logic [63:0] exp_line;
      buf_base = {$urandom, $urandom} & ~64'h3F; num_lines = 16'd5;
      start = 1'b1; cycle(); start = 1'b0;
      res_valid = 1'b1;
      for (int c = 0; c < 20 && g < 2; c++) begin
         cycle();
         if (last_gr) g++;
      end
      res_valid = 1'b0;
      idle_cycles(3);
      n_cmp++;
      if (offset_dbg !== 16'd2) begin
         n_err++;
         $display("FAIL collide_offset got %0d expected 2", offset_dbg);
      end
      res_valid = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      n_cmp++;
      if (last_gd || last_gr) begin
         n_err++;
         $display("FAIL collide_nogrant got grant expected none while start");
      end
      for (int c = 0; c < 10 && !hit; c++) begin
         cycle();
         hit = last_gr;
      end
      exp_line = buf_base >> 6;
      n_cmp++;
      if (!hit || cci.wr_addr !== exp_line[31:0]) begin
         n_err++;
         $display("FAIL collide_addr got %h expected %h (offset 0)", cci.wr_addr, exp_line[31:0]);
      end
      res_valid = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_reset_midpass();
      bit          hit = 0;
      logic [63:0] exp_line;
      write_fence = 1'b1; num_lines = 16'd4;
      start = 1'b1; cycle(); start = 1'b0;
      res_valid = 1'b1;
      for (int c = 0; c < 10 && !hit; c++) begin
         cycle();
         hit = last_gr;
      end
      res_valid = 1'b1;
      cycle(); // second line granted three cycles later is fine; we now sit in a later state
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         cycle();
         hit = last_gr;
      end
      // Now in SEND with offset already advanced: reset here.
      resetb = 1'b0;
      cycle();
      n_cmp++;
      if (cci.wr_valid !== 1'b0 || offset_dbg !== 16'd0 || tx_count !== 32'd0) begin
         n_err++;
         $display("FAIL midpass_reset got valid=%b offset=%0d tx=%0d expected 0/0/0", cci.wr_valid, offset_dbg, tx_count);
      end
      resetb = 1'b1;
      hit = 0;
      for (int c = 0; c < 10 && !hit; c++) begin
         cycle();
         hit = (cci.wr_valid === 1'b1);
      end
      exp_line = buf_base >> 6;
      n_cmp++;
      if (!hit || cci.wr_type !== WR_FENCE || cci.wr_addr !== exp_line[31:0]) begin
         n_err++;
         $display("FAIL midpass_fence got type=%h addr=%h expected %h/%h", cci.wr_type, cci.wr_addr, WR_FENCE, exp_line[31:0]);
      end
      write_fence = 1'b0; res_valid = 1'b0;
      idle_cycles(3);
   endtask

   task automatic test_random();
      num_lines = 16'($urandom_range(1, 6));
      buf_base  = {$urandom, $urandom};
      start = 1'b1; cycle(); start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (last_gd || !dsm_req) begin
            dsm_req    = ($urandom_range(0, 2) == 0);
            dsm_base   = {$urandom, $urandom};
            dsm_offset = 10'($urandom_range(0, 1023));
            dsm_data   = rand512();
         end
         res_valid      = $urandom_range(0, 1);
         res_data       = rand512();
         cci.almostfull = ($urandom_range(0, 4) == 0);
         write_fence    = $urandom_range(0, 1);
         start          = ($urandom_range(0, 29) == 0);
         cycle();
      end
      dsm_req = 1'b0; res_valid = 1'b0; start = 1'b0; cci.almostfull = 1'b0;
      idle_cycles(4);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_dsm_only();
      test_result_pass();
      test_starvation();
      test_backpressure();
      test_start_collision();
      test_reset_midpass();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
